systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Sequencer for an N x N weight-free systolic array of signed int8 MAC processing elements (PEs). Each PE accumulates into a 32-bit sum, clears on its reset, and forwards a right and b down.
- Per job: clears the array, generates skewed per-row A and per-column B operand fetch indices with valid masks, waits out pipeline drain, then streams the N result rows out under a valid/ready handshake.
- Sits between the host command interface, the A/B operand buffers and the result collector.

Parameters:
- N, 4, array dimension (rows = columns = N), 2..16.
- K_MAX, 256, maximum reduction depth per job.
- KW, $clog2(K_MAX+1), width of k_len and k indices.
- RW, $clog2(N) (min 1), width of rd_row.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KW  reduction depth K, captured with start; 0..K_MAX.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result row handshake.
- pe_clr  out  1  drives the PE array reset (clears sums and pipeline regs).
- a_row_vld  out  N  bit i: row i must be fed A[i][a_k_idx_i]; when low the datapath feeds 0.
- a_k_idx  out  N*KW  packed, lane i at [i*KW +: KW]; A column index for row i.
- b_col_vld  out  N  bit j: column j must be fed B[b_k_idx_j][j]; when low the datapath feeds 0.
- b_k_idx  out  N*KW  packed; B row index for column j.
- rd_row  out  RW  index of the result row currently presented.
- rd_valid  out  1  result row rd_row is stable in the array sums.
- rd_ready  in  1  collector accepts the row.

Behaviour:
- Reset: state IDLE. busy=0, done=0, pe_clr=0, rd_valid=0, rd_row=0, all vld=0, all idx=0, cycle counter t=0. Reset mid-job aborts immediately; no done.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> READ -> IDLE.
- IDLE: on start=1, capture K=k_len and go to CLEAR. Start outside IDLE is ignored, not queued.
- CLEAR: exactly 1 cycle with pe_clr=1; t is set to 0. Go to FEED.
- FEED: lasts K+2N-2 cycles, t = 0..K+2N-3, then go to DRAIN.
  - a_row_vld[i] = (t >= i) && (t-i < K), with a_k_idx_i = t-i.
  - b_col_vld[j] uses the same rule, with b_k_idx_j = t-j.
  - When a lane is invalid its idx is 0.
  - Skew guarantee: PE(i,j) receives A[i][k] and B[k][j] in the same cycle t = k+i+j.
  - Outputs are registered: vld/idx for cycle t appear at the outputs during FEED cycle t. The datapath supplies operands combinationally from idx in the same cycle.
- DRAIN: 1 cycle, all vld=0. This lets the final MAC of PE(N-1,N-1) register.
- READ: rd_valid=1 and rd_row starts at 0.
  - On rd_valid && rd_ready, rd_row increments.
  - On the handshake with rd_row=N-1: rd_valid drops next cycle, done pulses for 1 cycle, state returns to IDLE.
  - rd_row holds while rd_ready=0; there is no timeout.
  - The array receives no further operands (all vld=0), so sums stay stable.
- K=0: FEED still runs 2N-2 cycles with every vld=0; the readout returns all-zero sums.
- k_len > K_MAX: saturated to K_MAX on capture.
- busy=1 from the CLEAR cycle through the final READ cycle. done and busy are never both high; done is asserted in IDLE.
- Job latency from start to first rd_valid: 1 (CLEAR) + K+2N-2 (FEED) + 1 (DRAIN) cycles, plus 1 cycle of start registration.

Test Plan:
- N=4, K=3, A=I, B=[1..12]: check the full vld/idx trace. Row 2 is valid at t=2..4 with idx 0,1,2. The FEED phase is 9 cycles. Rows read out equal B's rows.
- N=4, K=5, random int8 A/B with rd_ready held high: 4 consecutive rd_valid cycles, rd_row 0..3. Sums match the golden int32 matmul, including -128*-128 products. done pulses once.
- Same job with rd_ready toggled 0,1,0,0,1...: rd_row holds while rd_ready=0. Data is unchanged and no row is skipped or duplicated.
- K=0: pe_clr pulses, then 6 FEED cycles with all vld=0. All sums read 0 and done pulses.
- start pulsed during FEED and READ: ignored. Back-to-back jobs (second start in the cycle after done) are accepted, and the second job's pe_clr clears the first job's sums.
- rst asserted mid-FEED: next cycle busy=0, vld=0, pe_clr=0, no done. A new start then completes normally.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Signal bundle between the systolic array sequencer and the host, the operand buffers and the result collector.
interface systolic_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 9,
    parameter int RW = 2
);
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            done;
    logic            pe_clr;
    logic [N-1:0]    a_row_vld;
    logic [N*KW-1:0] a_k_idx;
    logic [N-1:0]    b_col_vld;
    logic [N*KW-1:0] b_k_idx;
    logic [RW-1:0]   rd_row;
    logic            rd_valid;
    logic            rd_ready;
    logic [2:0]      dbg_state;

    // Readout handshake: row rd_row transfers on a rising clk edge with rd_valid && rd_ready;
    // once raised, rd_valid stays high and rd_row stays put until that transfer happens.
    modport master (
        output start, k_len, rd_ready,
        input  busy, done, pe_clr, a_row_vld, a_k_idx, b_col_vld, b_k_idx,
               rd_row, rd_valid, dbg_state
    );

    modport slave (
        input  start, k_len, rd_ready,
        output busy, done, pe_clr, a_row_vld, a_k_idx, b_col_vld, b_k_idx,
               rd_row, rd_valid, dbg_state
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N systolic MAC array: clear, skewed operand feed, drain, row readout.
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int K_MAX = 256,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int RW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    systolic_ctrl_if.slave bus
);
    localparam int TW = $clog2(K_MAX + 2 * N);
    localparam logic [KW-1:0] K_SAT = KW'(K_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   t, t_d;
    logic [KW-1:0]   k, k_d;
    logic [RW-1:0]   row, row_d;
    logic [KW-1:0]   k_cap;
    logic [TW-1:0]   t_last;

    logic            busy_d, done_d, pe_clr_d, rd_valid_d;
    logic [N-1:0]    a_vld_d, b_vld_d;
    logic [N*KW-1:0] a_idx_d, b_idx_d;

    assign k_cap  = (int'(bus.k_len) > K_MAX) ? K_SAT : bus.k_len;
    assign t_last = TW'(k) + TW'(2 * N - 3);

    assign bus.rd_row    = row;
    assign bus.dbg_state = state;

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            t             <= '0;
            k             <= '0;
            row           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pe_clr    <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.a_row_vld <= '0;
            bus.a_k_idx   <= '0;
            bus.b_col_vld <= '0;
            bus.b_k_idx   <= '0;
        end else begin
            state         <= state_d;
            t             <= t_d;
            k             <= k_d;
            row           <= row_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
            bus.pe_clr    <= pe_clr_d;
            bus.rd_valid  <= rd_valid_d;
            bus.a_row_vld <= a_vld_d;
            bus.a_k_idx   <= a_idx_d;
            bus.b_col_vld <= b_vld_d;
            bus.b_k_idx   <= b_idx_d;
        end
    end

    always_comb begin
        state_d = state;
        t_d     = t;
        k_d     = k;
        row_d   = row;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CLEAR;
                    k_d     = k_cap;
                    t_d     = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                t_d     = '0;
            end
            ST_FEED: begin
                if (t == t_last) begin
                    state_d = ST_DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_READ;
                row_d   = '0;
            end
            ST_READ: begin
                if (bus.rd_ready) begin
                    if (row == RW'(N - 1)) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane i (row for A, column for B) carries reduction index t-i while 0 <= t-i < K.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state == ST_READ) && (state_d == ST_IDLE);
        pe_clr_d   = (state_d == ST_CLEAR);
        rd_valid_d = (state_d == ST_READ);
        a_vld_d    = '0;
        a_idx_d    = '0;
        b_vld_d    = '0;
        b_idx_d    = '0;
        if (state_d == ST_FEED) begin
            for (int i = 0; i < N; i++) begin
                if ((t_d >= TW'(i)) && ((t_d - TW'(i)) < TW'(k_d))) begin
                    a_vld_d[i]            = 1'b1;
                    b_vld_d[i]            = 1'b1;
                    a_idx_d[i*KW +: KW]   = KW'(t_d - TW'(i));
                    b_idx_d[i*KW +: KW]   = KW'(t_d - TW'(i));
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Drives systolic_ctrl with a behavioural PE array and checks traces and readout against a golden matmul.
module tb_systolic_ctrl;
    localparam int N     = 4;
    localparam int K_MAX = 8;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int RW    = $clog2(N);
    localparam int KD    = 16;
    localparam int CW    = N * 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    systolic_ctrl_if #(.N(N), .KW(KW), .RW(RW)) bus ();

    systolic_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int jobs     = 0;

    logic [CW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural PE array fed from the sequencer's indices.
    logic signed [7:0]  a_mat [N][KD];
    logic signed [7:0]  b_mat [KD][N];
    logic signed [7:0]  a_in  [N][N];
    logic signed [7:0]  b_in  [N][N];
    logic signed [7:0]  a_reg [N][N];
    logic signed [7:0]  b_reg [N][N];
    logic signed [31:0] sum_arr [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = bus.a_row_vld[i] ? a_mat[i][bus.a_k_idx[i*KW +: KW]] : 8'sd0;
            for (int j = 1; j < N; j++) a_in[i][j] = a_reg[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j] = bus.b_col_vld[j] ? b_mat[bus.b_k_idx[j*KW +: KW]][j] : 8'sd0;
            for (int i = 1; i < N; i++) b_in[i][j] = b_reg[i-1][j];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (bus.pe_clr) begin
                    a_reg[i][j]   <= 8'sd0;
                    b_reg[i][j]   <= 8'sd0;
                    sum_arr[i][j] <= 32'sd0;
                end else begin
                    a_reg[i][j]   <= a_in[i][j];
                    b_reg[i][j]   <= b_in[i][j];
                    sum_arr[i][j] <= sum_arr[i][j] + 32'(int'(a_in[i][j]) * int'(b_in[i][j]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            check("done_excl_busy", CW'(bus.busy), '0);
        end
    end

    function automatic logic [CW-1:0] model_row(input logic [RW-1:0] r);
        logic [CW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*32 +: 32] = sum_arr[r][j];
        return v;
    endfunction

    function automatic logic [CW-1:0] golden_row(input int r, input int k);
        logic [CW-1:0] v;
        int acc;
        v = '0;
        for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int kk = 0; kk < k; kk++) acc += int'(a_mat[r][kk]) * int'(b_mat[kk][j]);
            v[j*32 +: 32] = 32'(acc);
        end
        return v;
    endfunction

    task automatic load_random(input int k);
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < KD; kk++) begin
                a_mat[i][kk] = 8'($urandom_range(0, 255));
                b_mat[kk][i] = 8'($urandom_range(0, 255));
            end
        a_mat[0][0] = -8'sd128;
        b_mat[0][0] = -8'sd128;
        if (k > 1) begin
            a_mat[N-1][k-1] = -8'sd128;
            b_mat[k-1][N-1] = -8'sd128;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("idle_outs", CW'({bus.busy, bus.done, bus.pe_clr, bus.rd_valid}), '0);
        end
    endtask

    // Runs one job starting at the current negedge and returns at the negedge where done is high.
    task automatic run_job(input int klen, input int rmode, input bit poke);
        int k, feed, exp_row, cyc;
        logic [N-1:0] ev;
        logic [N*KW-1:0] ei;
        logic [4:0] pat;
        pat  = 5'b10010;
        k    = (klen > K_MAX) ? K_MAX : klen;
        feed = k + 2 * N - 2;
        for (int r = 0; r < N; r++) exp_q.push_back(golden_row(r, k));
        jobs++;
        bus.start = 1'b1;
        bus.k_len = KW'(klen);
        @(negedge clk);
        bus.start = 1'b0;
        check("clear_pe_clr", CW'(bus.pe_clr), 1);
        check("clear_busy_done", CW'({bus.busy, bus.done, bus.rd_valid}), CW'(3'b100));
        check("clear_vld", CW'({bus.a_row_vld, bus.b_col_vld}), '0);
        for (int t = 0; t < feed; t++) begin
            @(negedge clk);
            ev = '0;
            ei = '0;
            for (int i = 0; i < N; i++) begin
                if (t >= i && t - i < k) begin
                    ev[i]          = 1'b1;
                    ei[i*KW +: KW] = KW'(t - i);
                end
            end
            check("feed_a_vld", CW'(bus.a_row_vld), CW'(ev));
            check("feed_a_idx", CW'(bus.a_k_idx), CW'(ei));
            check("feed_b_vld", CW'(bus.b_col_vld), CW'(ev));
            check("feed_b_idx", CW'(bus.b_k_idx), CW'(ei));
            check("feed_ctl", CW'({bus.busy, bus.pe_clr, bus.rd_valid, bus.done}), CW'(4'b1000));
            bus.start = poke && (t == 2);
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rd_ready = 1'b0;
        check("drain_outs", CW'({bus.a_row_vld, bus.b_col_vld, bus.rd_valid, bus.pe_clr}), '0);
        check("drain_busy", CW'(bus.busy), 1);
        exp_row = 0;
        cyc     = 0;
        while (exp_row < N && cyc < 200) begin
            @(negedge clk);
            check("read_valid", CW'({bus.rd_valid, bus.busy}), CW'(2'b11));
            check("read_no_vld", CW'({bus.a_row_vld, bus.b_col_vld}), '0);
            check("read_row", CW'(bus.rd_row), CW'(exp_row));
            if (exp_q.size() > 0) check("read_data", model_row(bus.rd_row), exp_q[0]);
            bus.start = poke && (cyc == 0);
            case (rmode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = pat[cyc % 5];
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.rd_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                exp_row++;
            end
            cyc++;
        end
        if (exp_row < N) check("read_timeout", CW'(exp_row), CW'(N));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rd_ready = 1'b0;
        check("done_pulse", CW'(bus.done), 1);
        check("done_state", CW'({bus.busy, bus.rd_valid, bus.rd_row}), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.k_len    = '0;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < KD; kk++) begin
                a_mat[i][kk] = 8'sd0;
                b_mat[kk][i] = 8'sd0;
            end
        repeat (3) @(negedge clk);
        check("rst_busy", CW'(bus.busy), '0);
        check("rst_done", CW'(bus.done), '0);
        check("rst_pe_clr", CW'(bus.pe_clr), '0);
        check("rst_rd", CW'({bus.rd_valid, bus.rd_row}), '0);
        check("rst_vld", CW'({bus.a_row_vld, bus.b_col_vld}), '0);
        check("rst_idx", CW'({bus.a_k_idx, bus.b_k_idx}), '0);
        rst = 1'b0;
        idle_cycles(2);

        // A = identity (4x3), B = 1..12 (3x4)
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < 3; kk++) a_mat[i][kk] = (i == kk) ? 8'sd1 : 8'sd0;
        for (int kk = 0; kk < 3; kk++)
            for (int j = 0; j < N; j++) b_mat[kk][j] = 8'(kk * N + j + 1);
        check("golden_row2_is_b2", golden_row(2, 3), {32'd12, 32'd11, 32'd10, 32'd9});
        run_job(3, 0, 1'b0);
        idle_cycles(2);

        load_random(5);
        run_job(5, 0, 1'b0);
        idle_cycles(2);
        run_job(5, 1, 1'b0);
        idle_cycles(2);

        run_job(0, 2, 1'b0);
        idle_cycles(2);

        load_random(4);
        run_job(4, 0, 1'b1);
        load_random(2);
        run_job(2, 2, 1'b0);
        idle_cycles(2);

        load_random(K_MAX);
        run_job(12, 2, 1'b0);
        idle_cycles(2);

        // Abort mid-FEED
        bus.start = 1'b1;
        bus.k_len = KW'(5);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctl", CW'({bus.busy, bus.done, bus.pe_clr, bus.rd_valid}), '0);
        check("abort_vld", CW'({bus.a_row_vld, bus.b_col_vld}), '0);
        rst = 1'b0;
        idle_cycles(2);
        load_random(3);
        run_job(3, 0, 1'b0);
        idle_cycles(3);

        check("done_count", CW'(done_cnt), CW'(jobs));
        check("queue_empty", CW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
